// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: clock divider, h/v counters and combinational
// sync/active/coordinate decodes from the registered counters.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int CLK_DIV  = 2
) (
   input  logic       clk_in,
   input  logic       i_rst,
   output logic       o_pix_stb,
   output logic       o_hs,
   output logic       o_vs,
   output logic       o_active,
   output logic [9:0] o_x,
   output logic [8:0] o_y,
   output logic       o_frame,
   output logic       o_line
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [DIV_W-1:0] div_q, div_d;
   logic [9:0]       h_q, h_d;
   logic [9:0]       v_q, v_d;
   logic             pix_stb;
   logic             h_wrap;

   assign pix_stb = (div_q == DIV_LAST);
   assign h_wrap  = (h_q == H_LAST);

   always_comb begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      h_d   = h_q;
      v_d   = v_q;
      if (pix_stb) begin
         if (h_wrap) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
         end else begin
            h_d = h_q + 10'd1;
         end
      end
   end

   always_ff @(posedge clk_in or negedge i_rst) begin
      if (!i_rst) begin
         div_q <= '0;
         h_q   <= '0;
         v_q   <= '0;
      end else begin
         div_q <= div_d;
         h_q   <= h_d;
         v_q   <= v_d;
      end
   end

   // Decodes stay combinational so they line up with the counters; the
   // renderer's registered color lags sync by one clk_in, which is accepted.
   assign o_pix_stb = pix_stb;
   assign o_active  = (h_q < H_ACT) && (v_q < V_ACT);
   assign o_hs      = !((h_q >= HS_BEG) && (h_q < HS_END));
   assign o_vs      = !((v_q >= VS_BEG) && (v_q < VS_END));
   assign o_x       = o_active ? h_q : 10'd0;
   assign o_y       = o_active ? v_q[8:0] : 9'd0;
   assign o_line    = pix_stb && h_wrap;
   assign o_frame   = pix_stb && h_wrap && (v_q == V_LAST);

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing from the 50 MHz board clock.
- Produces the pixel coordinates (o_x, o_y) and active-area flag (o_active) consumed directly by the menu/game pixel renderers, whose `color` output is registered on the same clk_in.
- Drives the hsync/vsync pins and supplies a frame-start strobe that downstream logic uses to update positions between frames.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, clk_in cycles per pixel (50 MHz / 2 = 25 MHz pixel rate); legal range 1..16

Ports:
- clk_in  input  1  board clock, 50 MHz
- i_rst  input  1  asynchronous active-low reset
- o_pix_stb  output  1  one-clk_in-cycle pixel strobe; the counters advance on it
- o_hs  output  1  horizontal sync, active low
- o_vs  output  1  vertical sync, active low
- o_active  output  1  high while (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE)
- o_x  output  10  current column, 0..H_ACTIVE-1; 0 outside the active area
- o_y  output  9  current row, 0..V_ACTIVE-1; 0 outside the active area
- o_frame  output  1  one-clk_in-cycle pulse when a new frame begins
- o_line  output  1  one-clk_in-cycle pulse when a new line begins

Behaviour:
- Totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800.
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525.
  - Internal counters h_cnt and v_cnt are 10 bits; H_TOTAL and V_TOTAL must both be <= 1024.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 on every clk_in edge and wraps to 0.
  - o_pix_stb = (div_cnt == CLK_DIV-1), a combinational decode of the register.
  - With CLK_DIV=1, o_pix_stb is constantly 1 after reset.
- Horizontal counter (on clk_in edges where o_pix_stb=1):
  - h_cnt increments.
  - At H_TOTAL-1 it wraps to 0.
- Vertical counter (on the same edge as the h_cnt wrap):
  - v_cnt increments.
  - At V_TOTAL-1 it wraps to 0.
  - Both counters wrap simultaneously at (799,524) -> (0,0).
- Output decodes (all combinational from registered counters, so valid in the same cycle the counters change):
  - o_hs = 0 iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - o_vs = 0 iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491).
  - o_x = o_active ? h_cnt : 0.
  - o_y = o_active ? v_cnt[8:0] : 0.
  - o_line = o_pix_stb & (h_cnt == H_TOTAL-1), i.e. asserted in the cycle before h wraps.
  - o_frame = o_line & (v_cnt == V_TOTAL-1).
- Reset (i_rst=0, asynchronous):
  - div_cnt=0, h_cnt=0, v_cnt=0 immediately, including mid-line or mid-frame.
  - Resulting outputs: o_active=1, o_x=0, o_y=0, o_hs=1, o_vs=1, o_line=0, o_frame=0.
  - o_pix_stb=0 if CLK_DIV>1, else 1.
- Reset release:
  - Deassertion is sampled on clk_in.
  - The first o_pix_stb occurs CLK_DIV-1 edges after release.
- Each (o_x,o_y) value holds for exactly CLK_DIV clk_in cycles.
- Downstream renderers register color one clk_in later. The resulting one-clk_in skew versus o_hs/o_vs is accepted and not compensated here.
- No other inputs; the block free-runs.

Test Plan:
- Reset check: assert i_rst=0 mid-frame (h=300,v=200) -> outputs go to reset values within the same cycle with no clock edge; o_x=0, o_y=0, o_hs=1, o_vs=1.
- Line timing: after release, count clk_in cycles:
  - o_line period = 1600 cycles.
  - o_hs low for exactly 192 cycles, starting 1312 cycles after line start.
  - o_active high for 1280 cycles per visible line.
- Frame timing:
  - o_frame period = 840000 cycles.
  - o_vs low for exactly 2 lines (3200 cycles), beginning at v_cnt=490.
  - o_active is never high for v_cnt >= 480.
- Coordinates:
  - At h_cnt=639, v_cnt=479: o_x=639, o_y=479, o_active=1.
  - Next pixel: o_active=0, o_x=0, o_y=0.
  - Wrap from (799,524) -> (0,0) coincides with the o_frame pulse cycle + 1.
- CLK_DIV=1 build: o_pix_stb stuck at 1; line period 800 cycles; frame period 420000 cycles; hsync width 96 cycles.
- Renderer co-sim: drive a menu renderer with o_active/o_x/o_y -> its color is 1 at (x=200,y=200) in the frame, sampled one clk_in after the coordinate appears; color is 0 whenever o_active=0.
